// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG conditioning path.
package trng_pkg;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_t;

  localparam int TRNG_BYTE_W      = 8;
  localparam int TRNG_RCT_DEFAULT = 32;

endpackage

// File: rtl/trng_sync.sv
// Multi-flop synchroniser for asynchronous inputs such as the raw entropy bit.
module trng_sync #(
  parameter int DATA_W      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trng_conditioner.sv
// Entropy post-processing: sync, repetition-count health test, Von Neumann
// debias, byte packing and a valid/ready output register.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RCT_LIMIT   = TRNG_RCT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   raw_bit,
  output logic [TRNG_BYTE_W-1:0] rnd_byte,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic                   health_fail,
  input  logic                   clear_fail
);

  localparam logic [3:0] PK_FULL = 4'(TRNG_BYTE_W);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                   s;
  logic [7:0]             rep_cnt, rep_nxt;
  logic                   last;
  logic                   trip, block, pk_clr;
  vn_state_t              vn_state, vn_nxt;
  logic                   vn_a, emit;
  logic [3:0]             pk_cnt;
  logic [TRNG_BYTE_W-1:0] pk_sh, sh_nxt;
  logic                   out_free, load;
  logic [TRNG_BYTE_W-1:0] load_byte;

  trng_sync #(.DATA_W(1), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (raw_bit),
    .dout (s)
  );

  // Sample stage: repetition-count health test
  always_comb begin
    rep_nxt = rep_cnt;
    if (en) rep_nxt = (rep_cnt != 8'd0 && s == last) ? sat_inc(rep_cnt) : 8'd1;
  end

  assign trip   = en && (rep_nxt == 8'(RCT_LIMIT));
  assign block  = !clear_fail && (health_fail || trip);
  assign pk_clr = clear_fail || block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt     <= 8'd0;
      last        <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (clear_fail) begin
        rep_cnt     <= 8'd0;
        health_fail <= 1'b0;
      end else begin
        rep_cnt <= rep_nxt;
        if (en) last <= s;
        if (trip) health_fail <= 1'b1;
      end
    end
  end

  // Debias stage: Von Neumann pair extractor
  always_comb begin
    vn_nxt = vn_state;
    emit   = 1'b0;
    if (!en) begin
      vn_nxt = VN_FIRST;
    end else begin
      case (vn_state)
        VN_FIRST:  vn_nxt = VN_SECOND;
        VN_SECOND: begin
          vn_nxt = VN_FIRST;
          emit   = (s != vn_a);
        end
        default:   vn_nxt = VN_FIRST;
      endcase
    end
    if (pk_clr) begin
      vn_nxt = VN_FIRST;
      emit   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vn_state <= VN_FIRST;
      vn_a     <= 1'b0;
    end else begin
      vn_state <= vn_nxt;
      if (en && vn_state == VN_FIRST) vn_a <= s;
    end
  end

  // Pack stage: shift register plus output holding register
  assign out_free  = !rnd_valid || rnd_ready;
  assign sh_nxt    = {pk_sh[TRNG_BYTE_W-2:0], vn_a};
  assign load      = !pk_clr && out_free &&
                     ((pk_cnt == PK_FULL) || (emit && pk_cnt == PK_FULL - 4'd1));
  assign load_byte = (pk_cnt == PK_FULL) ? pk_sh : sh_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_cnt <= 4'd0;
      pk_sh  <= '0;
    end else if (pk_clr) begin
      pk_cnt <= 4'd0;
      pk_sh  <= '0;
    end else if (pk_cnt == PK_FULL) begin
      if (out_free) pk_cnt <= 4'd0;
    end else if (emit) begin
      pk_sh  <= sh_nxt;
      pk_cnt <= load ? 4'd0 : pk_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_byte  <= '0;
      rnd_valid <= 1'b0;
    end else if (block) begin
      rnd_valid <= 1'b0;
    end else if (load) begin
      rnd_byte  <= load_byte;
      rnd_valid <= 1'b1;
    end else if (rnd_valid && rnd_ready) begin
      rnd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: debias patterns, health test,
// backpressure, enable gaps and asynchronous reset.
module tb_trng_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       raw_bit;
  logic [7:0] rnd_byte;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       health_fail;
  logic       clear_fail;

  int n_vec  = 0;
  int n_miss = 0;

  // en must line up with the synchroniser delay of the raw bit it enables
  logic e_d1 = 1'b0;
  logic e_d2 = 1'b0;

  logic [7:0] cap_q[$];

  trng_conditioner #(.SYNC_STAGES(2), .RCT_LIMIT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_bit     (raw_bit),
    .rnd_byte    (rnd_byte),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .health_fail (health_fail),
    .clear_fail  (clear_fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rnd_valid && rnd_ready) cap_q.push_back(rnd_byte);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic e);
    en      = e_d2;
    raw_bit = r;
    step();
    e_d2 = e_d1;
    e_d1 = e;
  endtask

  task automatic pairs(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(a, 1'b1);
      cyc(b, 1'b1);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic expect_bytes(input string tag, input int n, input logic [7:0] val);
    int sz;
    sz = cap_q.size();
    chk({tag, "_count"}, 32'(sz), 32'(n));
    for (int i = 0; i < sz && i < n; i++) chk({tag, "_byte"}, 32'(cap_q[i]), 32'(val));
    cap_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    raw_bit    = 1'b0;
    rnd_ready  = 1'b1;
    clear_fail = 1'b0;
    #1;
    chk("rst_byte",  32'(rnd_byte), 32'h00);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_fail",  32'(health_fail), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // alternating 0,1: first byte latency, then 0x00 bytes
    pairs(1'b0, 1'b1, 8);
    cyc(1'b0, 1'b0);
    chk("alt_latency_early", 32'(rnd_valid), 32'h0);
    cyc(1'b0, 1'b0);
    chk("alt_latency_valid", 32'(rnd_valid), 32'h1);
    chk("alt_latency_byte",  32'(rnd_byte), 32'h00);
    pairs(1'b0, 1'b1, 8);
    flush(4);
    expect_bytes("alt", 2, 8'h00);

    pairs(1'b1, 1'b0, 16);
    flush(4);
    expect_bytes("ones", 2, 8'hFF);

    for (int i = 0; i < 8; i++) begin
      pairs(1'b0, 1'b1, 1);
      pairs(1'b1, 1'b0, 1);
    end
    flush(4);
    expect_bytes("x55", 2, 8'h55);

    // constant 1: trip on the 32nd sample
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("rct_before_trip", 32'(health_fail), 32'h0);
    cyc(1'b1, 1'b0);
    chk("rct_trip", 32'(health_fail), 32'h1);
    chk("rct_trip_valid", 32'(rnd_valid), 32'h0);
    pairs(1'b0, 1'b1, 8);
    flush(4);
    chk("rct_sticky", 32'(health_fail), 32'h1);
    expect_bytes("rct_blocked", 0, 8'h00);
    clear_fail = 1'b1;
    cyc(1'b0, 1'b0);
    clear_fail = 1'b0;
    chk("rct_clear", 32'(health_fail), 32'h0);
    pairs(1'b0, 1'b1, 8);
    flush(4);
    expect_bytes("rct_after_clear", 1, 8'h00);

    // backpressure: hold 0xFF, fill 0x00 behind it, drop extra bits
    rnd_ready = 1'b0;
    pairs(1'b1, 1'b0, 8);
    pairs(1'b0, 1'b1, 8);
    pairs(1'b1, 1'b0, 4);
    flush(4);
    chk("bp_hold_valid", 32'(rnd_valid), 32'h1);
    chk("bp_hold_byte",  32'(rnd_byte), 32'hFF);
    rnd_ready = 1'b1;
    cyc(1'b0, 1'b0);
    rnd_ready = 1'b0;
    chk("bp_second_valid", 32'(rnd_valid), 32'h1);
    chk("bp_second_byte",  32'(rnd_byte), 32'h00);
    expect_bytes("bp_first", 1, 8'hFF);
    rnd_ready = 1'b1;
    flush(3);
    chk("bp_drained", 32'(rnd_valid), 32'h0);
    expect_bytes("bp_second", 1, 8'h00);
    pairs(1'b0, 1'b1, 8);
    flush(4);
    expect_bytes("bp_dropped_lost", 1, 8'h00);

    // odd sample then en low: half-pair dropped, partial bits kept
    pairs(1'b1, 1'b0, 3);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    pairs(1'b0, 1'b1, 5);
    flush(4);
    expect_bytes("en_gap", 1, 8'hE0);

    // async reset with a held byte and 5 bits in the packer
    rnd_ready = 1'b0;
    pairs(1'b1, 1'b0, 8);
    pairs(1'b1, 1'b0, 5);
    flush(3);
    chk("rst_mid_pre_valid", 32'(rnd_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rnd_valid), 32'h0);
    chk("rst_mid_byte",  32'(rnd_byte), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    rnd_ready = 1'b1;
    pairs(1'b1, 1'b0, 7);
    flush(4);
    expect_bytes("rst_mid_partial", 0, 8'h00);
    pairs(1'b1, 1'b0, 1);
    flush(4);
    expect_bytes("rst_mid_full", 1, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
